serial_pattern_feeder: RTL

Parallel-to-serial stimulus stage that sits directly upstream of the serial sequence-detector FSMs on the board. It captures a WIDTH-bit pattern (typically from slide switches) on a load request and shifts it out MSB-first, one bit per programmable bit period. It also produces a per-bit strobe, so a downstream detector sees each bit exactly once. An optional continuous mode repeats the captured word with no gap, for overlapping-pattern tests.

---
 rtl/serial_pattern_feeder_pkg.sv | 8 +
 rtl/serial_pattern_feeder_if.sv | 14 +
 rtl/serial_pattern_feeder_bit_tick_gen.sv | 29 ++
 rtl/serial_pattern_feeder.sv | 68 ++++++
 4 files changed

// File: rtl/serial_pattern_feeder_pkg.sv
// serial_pattern_feeder_pkg: shared state encoding, idle line level and counter-width helper
package serial_pattern_feeder_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam logic IDLE_LEVEL = 1'b0;
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/serial_pattern_feeder_if.sv
// serial_pattern_feeder_if: load/data/cont request side and serial stream outputs
//   master drives load, data_in, cont; slave drives ready, busy, ser_out, bit_stb, done
interface serial_pattern_feeder_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             cont;
    logic             ready;
    logic             busy;
    logic             ser_out;
    logic             bit_stb;
    logic             done;
    modport master(output load, data_in, cont, input ready, busy, ser_out, bit_stb, done);
    modport slave(input load, data_in, cont, output ready, busy, ser_out, bit_stb, done);
endinterface

// File: rtl/serial_pattern_feeder_bit_tick_gen.sv
// bit_tick_gen: DIV-clock bit-period divider
//   clk, reset; clr restarts the period; en advances it; last marks the final tick of a run
//   tick: last cycle of the current bit period; stb: registered, high on the first cycle of a period
module bit_tick_gen
    import serial_pattern_feeder_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic last,
    output logic tick,
    output logic stb
);
    localparam int DW = clog2_min1(DIV);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
    logic [DW-1:0] div_cnt;
    assign tick = en && div_cnt == DLAST;
    always_ff @(posedge clk) begin
        if (reset || clr)
            div_cnt <= '0;
        else if (en)
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        // a new period starts after a load or after any tick that does not end the run
        stb <= !reset && (clr || (tick && !last));
    end
endmodule

// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder: captures a WIDTH-bit word on load and shifts it out MSB-first, one bit per DIV clocks
//   clk, reset (sync, active-high); bus: serial_pattern_feeder_if slave
//   (load/data_in/cont in; ready/busy/ser_out/bit_stb/done out)
module serial_pattern_feeder
    import serial_pattern_feeder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input logic clk,
    input logic reset,
    serial_pattern_feeder_if.slave bus
);
    localparam int BW = clog2_min1(WIDTH);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    state_t           state;
    logic [WIDTH-1:0] shreg, saved;
    logic [BW-1:0]    bit_cnt;
    logic             ser_q, busy_q, done_q, tick, stb, start, word_end;
    assign start    = state == IDLE && bus.load;
    assign word_end = tick && bit_cnt == BLAST;
    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (start),
        .en   (state == SHIFT),
        .last (word_end && !bus.cont),
        .tick (tick),
        .stb  (stb)
    );
    // ser_out is registered, so it is loaded with the bit that shreg[WIDTH-1] will hold next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            saved   <= '0;
            bit_cnt <= '0;
            ser_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= word_end;
            if (start) begin
                state   <= SHIFT;
                shreg   <= bus.data_in;
                saved   <= bus.data_in;
                bit_cnt <= '0;
                ser_q   <= bus.data_in[WIDTH-1];
                busy_q  <= 1'b1;
            end else if (word_end) begin
                bit_cnt <= '0;
                shreg   <= bus.cont ? saved : shreg << 1;
                ser_q   <= bus.cont ? saved[WIDTH-1] : IDLE_LEVEL;
                busy_q  <= bus.cont;
                state   <= bus.cont ? SHIFT : IDLE;
            end else if (tick) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
                ser_q   <= shreg[WIDTH-2];
            end
        end
    end
    assign bus.ready   = state == IDLE;
    assign bus.busy    = busy_q;
    assign bus.ser_out = ser_q;
    assign bus.bit_stb = stb;
    assign bus.done    = done_q;
endmodule
